// File: rtl/preif_fetch_if.sv
// Fetch-side bus of the pre-IF stage: instruction-SRAM request plus the group handed to IF.
interface preif_fetch_if #(
    parameter int PC_W    = 32,
    parameter int FETCH_N = 2
);
    logic                next_allowin_i;
    logic                inst_sram_req_o;
    logic [PC_W-1:0]     inst_sram_raddr_o;
    logic                inst_sram_addr_ok_i;
    logic                to_next_valid_o;
    logic [PC_W-1:0]     to_next_pc_o;
    logic [FETCH_N-1:0]  to_next_mask_o;
    logic                to_next_adef_o;
    logic                to_next_cancel_o;

    modport master (
        input  next_allowin_i, inst_sram_addr_ok_i,
        output inst_sram_req_o, inst_sram_raddr_o, to_next_valid_o, to_next_pc_o,
               to_next_mask_o, to_next_adef_o, to_next_cancel_o
    );

    modport slave (
        output next_allowin_i, inst_sram_addr_ok_i,
        input  inst_sram_req_o, inst_sram_raddr_o, to_next_valid_o, to_next_pc_o,
               to_next_mask_o, to_next_adef_o, to_next_cancel_o
    );
endinterface

// File: rtl/preif_fetch_gen.sv
// Pre-IF fetch PC generator: group-aligned SRAM requests, redirect buffering while a request is held,
// flush handling. Define PREIF_ADEF_CHECK_EN to raise ADEF on misaligned fetch PCs.
module preif_fetch_gen #(
    parameter int              PC_W     = 32,
    parameter int              FETCH_N  = 2,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h1c000000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            excep_flush_i,
    input  logic            excep_en_i,
    input  logic [PC_W-1:0] excep_pc_i,
    input  logic            ertn_en_i,
    input  logic [PC_W-1:0] ertn_pc_i,
    input  logic            tlb_flush_en_i,
    input  logic [PC_W-1:0] tlb_flush_pc_i,
    input  logic            branch_en_i,
    input  logic [PC_W-1:0] branch_pc_i,
    preif_fetch_if.master   bus
);
    localparam int              G       = FETCH_N * 4;
    localparam logic [PC_W-1:0] G_W     = PC_W'(G);
    localparam logic [PC_W-1:0] ALIGN_M = ~PC_W'(G - 1);

    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2, EXC = 2'd3} state_t;

    state_t              state_r, state_s;
    logic [PC_W-1:0]     pc_r, pc_s, pend_pc_r, pend_pc_s;
    logic                pend_v_r, pend_v_s, pend_fl_r, pend_fl_s;
    logic [1:0]          pend_pri_r, pend_pri_s;
    logic                csr_v_s, redir_v_s, mis_s, take_s;
    logic [PC_W-1:0]     csr_pc_s, redir_pc_s, cur_s;
    logic [1:0]          redir_pri_s;
    logic                mrg_v_s, mrg_fl_s;
    logic [PC_W-1:0]     mrg_pc_s;
    logic [1:0]          mrg_pri_s;
    logic                req_s, valid_s, adef_s, cancel_s;
    logic [PC_W-1:0]     raddr_s, tpc_s;
    logic [FETCH_N-1:0]  mask_s;

    function automatic logic [PC_W-1:0] fix_pc(input logic [PC_W-1:0] pc);
`ifdef PREIF_ADEF_CHECK_EN
        return pc;
`else
        return pc & ~PC_W'(3);
`endif
    endfunction

    function automatic logic [PC_W-1:0] base_of(input logic [PC_W-1:0] pc);
        return pc & ALIGN_M;
    endfunction

    function automatic logic [FETCH_N-1:0] mask_of(input logic [PC_W-1:0] pc);
        logic [PC_W-1:0] slot;
        slot = (pc >> 2) & PC_W'(FETCH_N - 1);
        for (int i = 0; i < FETCH_N; i++) begin
            mask_of[i] = (PC_W'(i) >= slot);
        end
    endfunction

    // Redirect priority: excep > ertn > tlb_flush > branch (pri 0 is highest).
    always_comb begin
        csr_v_s = excep_en_i | ertn_en_i | tlb_flush_en_i;
        if (excep_en_i) begin
            csr_pc_s = excep_pc_i;  redir_pri_s = 2'd0;
        end else if (ertn_en_i) begin
            csr_pc_s = ertn_pc_i;   redir_pri_s = 2'd1;
        end else if (tlb_flush_en_i) begin
            csr_pc_s = tlb_flush_pc_i; redir_pri_s = 2'd2;
        end else begin
            csr_pc_s = tlb_flush_pc_i; redir_pri_s = 2'd3;
        end
        redir_v_s  = csr_v_s | branch_en_i;
        redir_pc_s = csr_v_s ? csr_pc_s : branch_pc_i;
    end

    // Merge this cycle's redirect/flush into the HOLD pending record; a latched higher priority PC is kept.
    always_comb begin
        take_s   = redir_v_s && (!pend_v_r || (redir_pri_s < pend_pri_r));
        mrg_fl_s = pend_fl_r | excep_flush_i;
        if (take_s) begin
            mrg_v_s = 1'b1;  mrg_pc_s = fix_pc(redir_pc_s); mrg_pri_s = redir_pri_s;
        end else begin
            mrg_v_s = pend_v_r; mrg_pc_s = pend_pc_r; mrg_pri_s = pend_pri_r;
        end
    end

    // Next-state and combinational fetch outputs.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        pend_v_s   = pend_v_r;
        pend_pc_s  = pend_pc_r;
        pend_pri_s = pend_pri_r;
        pend_fl_s  = pend_fl_r;
        req_s      = 1'b0;
        valid_s    = 1'b0;
        adef_s     = 1'b0;
        cancel_s   = 1'b0;
        cur_s      = fix_pc(redir_v_s ? redir_pc_s : pc_r);
`ifdef PREIF_ADEF_CHECK_EN
        mis_s      = (cur_s[1:0] != 2'b00);
`else
        mis_s      = 1'b0;
`endif
        raddr_s    = base_of(pc_r);
        tpc_s      = pc_r;
        mask_s     = mask_of(pc_r);
        case (state_r)
            RUN: begin
                raddr_s = base_of(cur_s);
                tpc_s   = cur_s;
                mask_s  = mask_of(cur_s);
                if (excep_flush_i) begin
                    if (csr_v_s) begin
                        pc_s = fix_pc(csr_pc_s);
                    end else begin
                        state_s = FLUSH;
                    end
                end else if (!bus.next_allowin_i) begin
                    pc_s = cur_s;
                end else if (mis_s) begin
                    valid_s = 1'b1;
                    adef_s  = 1'b1;
                    mask_s  = FETCH_N'(1'b1);
                    pc_s    = cur_s;
                    state_s = EXC;
                end else begin
                    req_s = 1'b1;
                    if (bus.inst_sram_addr_ok_i) begin
                        valid_s = 1'b1;
                        pc_s    = base_of(cur_s) + G_W;
                    end else begin
                        pc_s    = cur_s;
                        state_s = HOLD;
                    end
                end
            end
            HOLD: begin
                req_s = 1'b1;
                if (bus.inst_sram_addr_ok_i) begin
                    valid_s    = 1'b1;
                    cancel_s   = mrg_v_s | mrg_fl_s;
                    pend_v_s   = 1'b0;
                    pend_fl_s  = 1'b0;
                    pend_pri_s = 2'd3;
                    if (mrg_v_s) begin
                        pc_s = mrg_pc_s;  state_s = RUN;
                    end else if (mrg_fl_s) begin
                        state_s = FLUSH;
                    end else begin
                        pc_s = base_of(pc_r) + G_W;  state_s = RUN;
                    end
                end else begin
                    pend_v_s   = mrg_v_s;
                    pend_pc_s  = mrg_pc_s;
                    pend_pri_s = mrg_pri_s;
                    pend_fl_s  = mrg_fl_s;
                end
            end
            FLUSH: begin
                if (csr_v_s) begin
                    pc_s = fix_pc(csr_pc_s);  state_s = RUN;
                end else begin
                    state_s = FLUSH;
                end
            end
            EXC: begin
                if (csr_v_s) begin
                    pc_s = fix_pc(csr_pc_s);  state_s = RUN;
                end else if (excep_flush_i) begin
                    state_s = FLUSH;
                end else begin
                    state_s = EXC;
                end
            end
            default: begin
                state_s = RUN;
                pc_s    = RESET_PC;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            pc_r       <= RESET_PC;
            pend_v_r   <= 1'b0;
            pend_pc_r  <= {PC_W{1'b0}};
            pend_pri_r <= 2'd3;
            pend_fl_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pend_v_r   <= pend_v_s;
            pend_pc_r  <= pend_pc_s;
            pend_pri_r <= pend_pri_s;
            pend_fl_r  <= pend_fl_s;
        end
    end

    // Outputs forced low while reset is asserted; the request path is combinational for 0-cycle redirects.
    assign bus.inst_sram_req_o   = rst_n & req_s;
    assign bus.inst_sram_raddr_o = rst_n ? raddr_s : {PC_W{1'b0}};
    assign bus.to_next_valid_o   = rst_n & valid_s;
    assign bus.to_next_pc_o      = rst_n ? tpc_s : {PC_W{1'b0}};
    assign bus.to_next_mask_o    = rst_n ? mask_s : {FETCH_N{1'b0}};
    assign bus.to_next_cancel_o  = rst_n & cancel_s;
`ifdef PREIF_ADEF_CHECK_EN
    assign bus.to_next_adef_o    = rst_n & adef_s;
`else
    assign bus.to_next_adef_o    = 1'b0 & adef_s;
`endif
endmodule

// File: doc/preif_fetch_gen.md
Name: preif_fetch_gen

Overview:
- Parametrised next-generation pre-IF stage. Generates the fetch PC for a group of FETCH_N instructions and issues the instruction-SRAM request.
- Holds the request address stable until addr_ok. Buffers redirects that arrive while a request is outstanding. Raises the fetch-address-error (ADEF) exception.
- Sits between the CSR/ID redirect sources and the IF stage; replaces the external PC-buffer path with internal state.

Parameters:
- PC_W, 32, PC and address width.
- FETCH_N, 2, instructions per fetch group; power of two, 1..8.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- excep_flush_i  in  1  pipeline flush; the CSR redirect PC arrives on a later cycle.
- excep_en_i / excep_pc_i  in  1 / PC_W  exception entry redirect.
- ertn_en_i / ertn_pc_i  in  1 / PC_W  ertn return redirect.
- tlb_flush_en_i / tlb_flush_pc_i  in  1 / PC_W  TLB-instruction refetch redirect.
- branch_en_i / branch_pc_i  in  1 / PC_W  ID branch redirect.
- next_allowin_i  in  1  IF can accept a new group.
- inst_sram_req_o  out  1  fetch request.
- inst_sram_raddr_o  out  PC_W  group-aligned fetch address.
- inst_sram_addr_ok_i  in  1  address accepted.
- to_next_valid_o  out  1  group handed to IF this cycle.
- to_next_pc_o  out  PC_W  exact PC of first valid slot.
- to_next_mask_o  out  FETCH_N  per-slot valid; bit i = slot i.
- to_next_adef_o  out  1  ADEF on slot 0, no request made.
- to_next_cancel_o  out  1  IF must discard the returned data for this group.

Behaviour:
- Group size G = FETCH_N*4 bytes; OFS = log2(G).
- Aligned base = pc & ~(G-1). Slot index s = pc[OFS-1:2].
- Mask bit i = 1 for i >= s. Sequential next pc = base + G, wrapping modulo 2^PC_W.
- Redirect priority: excep > ertn > tlb_flush > branch > sequential. A redirect input is valid only in the cycle its enable is high.
- Registered state: pc_r, state, pend_v, pend_pc.
- Reset values: pc_r = RESET_PC, state = RUN, pend_v = 0. All outputs are 0 while rst_n is low.
- Reset mid-operation abandons any outstanding request with no cancel pulse.
- States: RUN, HOLD, FLUSH, EXC.
- Current pc (cur) in RUN = highest-priority redirect PC if any, else pc_r.
- RUN:
  - req = next_allowin_i & !excep_flush_i & !misaligned(cur); raddr = base(cur).
  - req & addr_ok: to_next_valid = 1, pc/mask from cur, cancel = 0; pc_r <= base(cur) + G; stay in RUN.
  - req & !addr_ok: pc_r <= cur; go to HOLD.
  - misaligned(cur) & next_allowin_i & !excep_flush_i: no req; to_next_valid = 1, adef = 1, mask = 1; go to EXC.
  - excep_flush_i: no req; go to FLUSH.
- HOLD:
  - req = 1 regardless of next_allowin_i; raddr = base(pc_r), held stable.
  - Any redirect or flush arriving here sets pend_v. Redirect PCs are latched into pend_pc by priority; a later lower-priority redirect does not overwrite a higher one already latched in the same HOLD episode. Flush alone sets a flush-pending flag.
  - On addr_ok: to_next_valid = 1, cancel = pend_v | flush-pending.
    - If a redirect PC is pending: pc_r <= pend_pc, go to RUN.
    - Else if a flush is pending: go to FLUSH.
    - Else: pc_r <= base + G, go to RUN.
    - Pending state clears.
- FLUSH:
  - req = 0. Branch inputs are ignored.
  - On excep/ertn/tlb_flush enable: pc_r <= that PC (priority applies), go to RUN; fetch starts the following cycle.
- EXC:
  - req = 0, to_next_valid = 0.
  - Leaves only via excep_flush_i (to FLUSH) or a CSR redirect (to RUN with that PC).
- A flush and a CSR redirect in the same cycle: the redirect wins; go to RUN with that PC, no request that cycle.
- Latency: redirect-to-request is 0 cycles in RUN (combinational) and 1 cycle from FLUSH/EXC.

Optional Feature:
- Macro PREIF_ADEF_CHECK_EN.
- Defined: misaligned(pc) = (pc[1:0] != 0), giving ADEF handling as above.
- Undefined: misaligned is constant 0, pc[1:0] is forced to 0 before use, the EXC state is unreachable, and to_next_adef_o is tied to 0.

Test Plan:
- Reset release, next_allowin_i = 1, addr_ok = 1 every cycle, FETCH_N = 2 → raddr 0x1c000000, 0x1c000008, 0x1c000010; mask 2'b11 each.
- Branch to 0x1c000104 in RUN → raddr 0x1c000100, mask 2'b10, to_next_pc_o 0x1c000104; next raddr 0x1c000108.
- addr_ok low for 3 cycles, branch to 0x1c000200 in the 2nd cycle → raddr stays 0x1c000010; on addr_ok, cancel = 1; next raddr 0x1c000200.
- excep_flush_i for 1 cycle, excep_en_i with 0x1c008000 the next cycle → req 0 for 2 cycles, then raddr 0x1c008000.
- Macro defined, branch to 0x1c000302 → no req, to_next_valid = 1, adef = 1; req stays 0 until excep_flush_i plus excep redirect.
- excep_en_i and branch_en_i in the same RUN cycle → the exception PC is used.
